// File: rtl/mt_pc_pkg.sv
// Shared fetch-stage definitions for the per-thread program counter bank.
// Holds the default thread count and PC width, the derived thread-id width,
// and the address / thread-id typedefs used by the RTL and the bench.
package mt_pc_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int NUM_THREADS   = 8;
  localparam int BITS_THREADS  = $clog2(NUM_THREADS);

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [BITS_THREADS-1:0]  tid_t;

  // Sequential fetch advances by one 32-bit instruction.
  localparam int PC_STEP = 4;

endpackage : mt_pc_pkg

// File: rtl/mt_pc_slot.sv
// One hardware thread's program counter register.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, loads RESET_PC
//   advance   this thread is fetching: pc <= pc + 4
//   redirect  taken branch/jump for this thread: pc <= target (wins over advance)
//   target    redirect address, taken verbatim
//   pc        registered PC of this thread
module mt_pc_slot
  import mt_pc_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = mt_pc_pkg::ADDRESS_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = {ADDRESS_WIDTH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] target,
  output logic [ADDRESS_WIDTH-1:0] pc
);

  // NOTE: state is written with non-blocking assignments so every slot and
  // every reader sees the pre-edge value within the same clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      // The redirect replaces the fetch advance; the +4 is dropped.
      pc <= target;
    end else if (advance) begin
      // Modulo 2^ADDRESS_WIDTH: wraps to zero past the top of the space.
      pc <= pc + ADDRESS_WIDTH'(PC_STEP);
    end
  end

endmodule : mt_pc_slot

// File: rtl/mt_pc.sv
// Per-thread program counter bank for the barrel-processor fetch stage.
// Presents the PC of the thread fetching this cycle (combinational on tid)
// and PC+4; the fetched thread advances by 4 each edge, and a taken
// branch/jump from Execute redirects the PC of the thread that issued it.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset, all PCs to RESET_PC
//   tid           thread fetching this cycle
//   pc_src_e      Execute redirect taken
//   branch_tid_e  thread owning the redirect
//   pc_target_e   redirect target address
//   pc            current PC of thread tid
//   pc_plus4      pc + 4 (wrapping)
module mt_pc
  import mt_pc_pkg::*;
#(
  parameter int                       NUM_THREADS   = mt_pc_pkg::NUM_THREADS,
  parameter int                       BITS_THREADS  = $clog2(NUM_THREADS),
  parameter int                       ADDRESS_WIDTH = mt_pc_pkg::ADDRESS_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = {ADDRESS_WIDTH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITS_THREADS-1:0]  tid,
  input  logic                     pc_src_e,
  input  logic [BITS_THREADS-1:0]  branch_tid_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4
);

  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];

  // One-hot decode of the fetching thread and the redirected thread; both
  // may hit different slots in the same edge.
  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_slot
    logic advance_en;
    logic redirect_en;

    assign advance_en  = (tid == BITS_THREADS'(i));
    assign redirect_en = pc_src_e && (branch_tid_e == BITS_THREADS'(i));

    mt_pc_slot #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .RESET_PC      (RESET_PC)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .advance  (advance_en),
      .redirect (redirect_en),
      .target   (pc_target_e),
      .pc       (pc_q[i])
    );
  end

  // NUM_THREADS is a power of two, so every tid value selects a real slot.
  assign pc       = pc_q[tid];
  assign pc_plus4 = pc + ADDRESS_WIDTH'(PC_STEP);

endmodule : mt_pc

// File: tb/tb_mt_pc.sv
// Self-checking bench for mt_pc. A behavioural model of the PC bank is
// updated on every rising edge; expected pc / pc_plus4 are pushed to a
// scoreboard queue when stimulus is driven and popped when the output is
// sampled, mid low-phase, well away from the rising edge.
`timescale 1ns / 100ps
module tb_mt_pc;
  import mt_pc_pkg::*;

  typedef struct {
    string tag;
    addr_t pc;
    addr_t pc4;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  tid_t  tid;
  logic  pc_src_e;
  tid_t  branch_tid_e;
  addr_t pc_target_e;
  addr_t pc;
  addr_t pc_plus4;

  addr_t model_pc [NUM_THREADS];
  exp_t  sb [$];
  int    tests_run = 0;
  int    tests_failed = 0;

  mt_pc dut (
    .clk          (clk),
    .rst          (rst),
    .tid          (tid),
    .pc_src_e     (pc_src_e),
    .branch_tid_e (branch_tid_e),
    .pc_target_e  (pc_target_e),
    .pc           (pc),
    .pc_plus4     (pc_plus4)
  );

  always #5 clk = ~clk;

  // Reference model: independent restatement of the per-thread update rule.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) model_pc[i] = '0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (pc_src_e && (branch_tid_e == tid_t'(i))) model_pc[i] = pc_target_e;
        else if (tid == tid_t'(i))                   model_pc[i] = model_pc[i] + 32'd4;
      end
    end
  end

  task automatic check(input string tag, input addr_t got, input addr_t exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input tid_t t);
    exp_t e;
    e.tag = tag;
    e.pc  = model_pc[t];
    e.pc4 = model_pc[t] + 32'd4;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc"}, pc, e.pc);
      check({e.tag, ".pc4"}, pc_plus4, e.pc4);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check the combinational read.
  task automatic drive(input string tag, input logic r, input tid_t t,
                       input logic src, input tid_t bt, input addr_t tgt);
    @(negedge clk);
    rst = r; tid = t; pc_src_e = src; branch_tid_e = bt; pc_target_e = tgt;
    push_exp(tag, t);
    #1;
    pop_cmp();
  endtask

  // Reads every thread within one low phase. Each thread is self-redirected
  // to its own value, so whichever is selected at the edge simply holds.
  task automatic peek_all(input string tag, input logic r);
    @(negedge clk);
    rst = r;
    pc_src_e = 1'b1;
    for (int i = 0; i < NUM_THREADS; i++) begin
      tid = tid_t'(i); branch_tid_e = tid_t'(i); pc_target_e = model_pc[i];
      push_exp($sformatf("%s.t%0d", tag, i), tid_t'(i));
      #0.5;
      pop_cmp();
    end
  endtask

  initial begin
    #100000;
    check("watchdog", 32'd1, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tid = '0; pc_src_e = 1'b0; branch_tid_e = '0; pc_target_e = '0;

    // 1. Reset edge, then sweep tid with rst held high.
    @(posedge clk);
    for (int i = 0; i < NUM_THREADS; i++) drive("reset", 1'b1, tid_t'(i), 1'b0, '0, '0);
    check("reset.const", pc, 32'h0);

    // 2. Round-robin, two passes over threads 0..3.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) drive($sformatf("rr%0d", p), 1'b0, tid_t'(i), 1'b0, '0, '0);
    peek_all("rr_after", 1'b0);

    // 3. Dwell on thread 3 for 10 edges.
    for (int k = 0; k < 10; k++) drive($sformatf("dwell%0d", k), 1'b0, tid_t'(3), 1'b0, '0, '0);
    peek_all("dwell_after", 1'b0);

    // 4. Cross-thread redirect: fetch thread 1, redirect thread 5.
    drive("xredir", 1'b0, tid_t'(1), 1'b1, tid_t'(5), 32'h100);
    peek_all("xredir_after", 1'b0);
    drive("xredir_t5", 1'b0, tid_t'(5), 1'b0, '0, '0);
    check("xredir_t5.const", pc, 32'h100);

    // 5. Same-thread conflict: redirect wins, advance dropped.
    drive("conflict", 1'b0, tid_t'(2), 1'b1, tid_t'(2), 32'h80);
    drive("conflict_rd", 1'b0, tid_t'(2), 1'b0, '0, '0);
    check("conflict.const_pc", pc, 32'h80);
    check("conflict.const_pc4", pc_plus4, 32'h84);

    // 6. Wrap-around on thread 0.
    drive("wrap_redir", 1'b0, tid_t'(3), 1'b1, tid_t'(0), 32'hFFFF_FFFC);
    drive("wrap_fetch", 1'b0, tid_t'(0), 1'b0, '0, '0);
    check("wrap.const_pc4", pc_plus4, 32'h0);
    drive("wrap_rd", 1'b0, tid_t'(0), 1'b0, '0, '0);

    // Unaligned target taken verbatim, then random traffic.
    drive("unaligned", 1'b0, tid_t'(6), 1'b1, tid_t'(7), 32'h1234_5677);
    for (int k = 0; k < 60; k++)
      drive("rand", 1'b0, tid_t'($urandom_range(NUM_THREADS - 1)), 1'($urandom_range(1)),
            tid_t'($urandom_range(NUM_THREADS - 1)), addr_t'($urandom));
    peek_all("rand_after", 1'b0);

    // Mid-run reset while threads hold non-zero PCs.
    drive("midrst", 1'b1, tid_t'(4), 1'b1, tid_t'(4), 32'hDEAD_BEEC);
    peek_all("midrst_hold", 1'b1);
    peek_all("midrst_after", 1'b0);
    check("midrst.const", pc, 32'h0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_mt_pc
